// File: rtl/quadrature_encoder_gen_if.sv
// Signal bundle for the quadrature encoder generator.
// Optional err_inj pin present only when QEP_GEN_ERR_INJ_EN is defined.
interface quadrature_encoder_gen_if #(
  parameter int unsigned COUNTER_WIDTH = 32
);
  logic                     en;
  logic                     cont;
  logic                     start;
  logic                     dir;
  logic [COUNTER_WIDTH-1:0] step_period;
  logic [COUNTER_WIDTH-1:0] move_cnt;
  logic [COUNTER_WIDTH-1:0] cnt_wrap;
  logic                     A_neg;
  logic                     B_neg;
  logic                     Z_neg;
  logic                     A;
  logic                     B;
  logic                     Z;
  logic [COUNTER_WIDTH-1:0] pos;
  logic                     busy;
  logic                     done_strobe;
`ifdef QEP_GEN_ERR_INJ_EN
  logic                     err_inj;
`endif

  modport master (
`ifdef QEP_GEN_ERR_INJ_EN
    output err_inj,
`endif
    output en, cont, start, dir, step_period, move_cnt, cnt_wrap,
    output A_neg, B_neg, Z_neg,
    input  A, B, Z, pos, busy, done_strobe
  );

  modport slave (
`ifdef QEP_GEN_ERR_INJ_EN
    input  err_inj,
`endif
    input  en, cont, start, dir, step_period, move_cnt, cnt_wrap,
    input  A_neg, B_neg, Z_neg,
    output A, B, Z, pos, busy, done_strobe
  );
endinterface

// File: rtl/quadrature_encoder_gen.sv
// Quadrature A/B/Z generator: continuous or counted moves at a programmable step rate.
// Define QEP_GEN_ERR_INJ_EN to add the err_inj double-step fault injection input.
module quadrature_encoder_gen #(
  parameter int unsigned COUNTER_WIDTH = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  quadrature_encoder_gen_if.slave bus
);
  localparam logic [COUNTER_WIDTH-1:0] ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_CONT, S_MOVE} state_t;

  state_t                   r_state, w_state_nx;
  logic [1:0]               r_phase, w_phase_nx;
  logic [COUNTER_WIDTH-1:0] r_pos, w_pos_nx;
  logic [COUNTER_WIDTH-1:0] r_timer, w_timer_nx;
  logic [COUNTER_WIDTH-1:0] r_remaining, w_remaining_nx;
  logic                     r_busy, w_busy_nx;
  logic                     r_done, w_done_nx;
  logic                     r_err_pend, w_err_pend_nx;
  logic                     w_edge;
  logic                     w_period_last;
  logic                     w_err_req;

`ifdef QEP_GEN_ERR_INJ_EN
  assign w_err_req = bus.err_inj;
`else
  assign w_err_req = 1'b0;
`endif

  // >= rather than == so a live shrink of step_period cannot strand the timer above the compare
  assign w_period_last = (bus.step_period != '0) && (r_timer >= (bus.step_period - ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_pos       <= '0;
      r_timer     <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_pend  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_phase     <= w_phase_nx;
      r_pos       <= w_pos_nx;
      r_timer     <= w_timer_nx;
      r_remaining <= w_remaining_nx;
      r_busy      <= w_busy_nx;
      r_done      <= w_done_nx;
      r_err_pend  <= w_err_pend_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_phase_nx     = r_phase;
    w_pos_nx       = r_pos;
    w_timer_nx     = r_timer;
    w_remaining_nx = r_remaining;
    w_done_nx      = 1'b0;
    w_edge         = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_timer_nx = '0;
        if (bus.en && bus.start && (bus.move_cnt != '0)) begin
          w_state_nx     = S_MOVE;
          w_remaining_nx = bus.move_cnt;
        end else if (bus.en && bus.cont) begin
          w_state_nx = S_CONT;
        end
        if (bus.en && bus.start && (bus.move_cnt == '0))
          w_done_nx = 1'b1;
      end
      S_CONT: begin
        if (!bus.en || !bus.cont) begin
          w_state_nx = S_IDLE;
          w_timer_nx = '0;
        end else if (w_period_last) begin
          w_edge     = 1'b1;
          w_timer_nx = '0;
        end else if (bus.step_period != '0) begin
          w_timer_nx = r_timer + ONE;
        end else begin
          w_timer_nx = '0;
        end
      end
      S_MOVE: begin
        if (!bus.en) begin
          w_state_nx     = S_IDLE;
          w_timer_nx     = '0;
          w_remaining_nx = '0;
        end else if (w_period_last) begin
          w_edge         = 1'b1;
          w_timer_nx     = '0;
          w_remaining_nx = r_remaining - ONE;
          if (r_remaining == ONE) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
          end
        end else if (bus.step_period != '0) begin
          w_timer_nx = r_timer + ONE;
        end else begin
          w_timer_nx = '0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_timer_nx = '0;
      end
    endcase

    if (w_edge) begin
      if (bus.dir) begin
        w_phase_nx = {~r_phase[0], r_phase[1]};
        w_pos_nx   = (r_pos == '0) ? bus.cnt_wrap : r_pos - ONE;
      end else begin
        w_phase_nx = {r_phase[0], ~r_phase[1]};
        w_pos_nx   = (r_pos == bus.cnt_wrap) ? '0 : r_pos + ONE;
      end
      // two phase steps in either direction is a complement of both bits
      if (r_err_pend)
        w_phase_nx = ~r_phase;
    end

    if ((r_state != S_IDLE) && (w_state_nx != S_IDLE))
      w_err_pend_nx = (r_err_pend && !w_edge) || w_err_req;
    else
      w_err_pend_nx = 1'b0;

    w_busy_nx = (w_state_nx != S_IDLE);
  end

  assign bus.A           = r_phase[1] ^ bus.A_neg;
  assign bus.B           = r_phase[0] ^ bus.B_neg;
  assign bus.Z           = (r_pos == '0) ^ bus.Z_neg;
  assign bus.pos         = r_pos;
  assign bus.busy        = r_busy;
  assign bus.done_strobe = r_done;
endmodule
